// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD display driver: FSM state encoding,
// active-low 7-segment patterns and the digit-count sanity function.
package bcd_display_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // True when N digits can represent the largest W-bit binary value.
  function automatic bit digits_fit(input int n_digits, input int w_bin);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int i = 0; i < n_digits; i++) begin
      pow10 = pow10 * 10;
    end
    max_bin = (longint'(1) << w_bin) - 1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_display_driver_seg7_encoder.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal nibbles and
// the explicit blank request both produce an unlit digit.
module seg7_encoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Captures a product on the rising edge of i_valid, converts it to BCD with a
// bit-serial double-dabble engine and drives held active-low 7-seg digits.
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int W_BIN    = 8,
  parameter int N_DIGITS = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [W_BIN-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic [7*N_DIGITS-1:0] o_seg,
  output state_e                o_state_dbg
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int SR_W  = BCD_W + W_BIN;
  localparam int CNT_W = $clog2(W_BIN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W_BIN - 1);

  if (!digits_fit(N_DIGITS, W_BIN)) begin : g_bad_params
    $error("N_DIGITS too small to hold a W_BIN-bit value");
  end

  state_e            state_q, state_d;
  logic              valid_q;
  logic [SR_W-1:0]   sr_q, sr_d, sr_adj, sr_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              done_q, done_d;
  logic              start;
  logic [N_DIGITS-1:0] blank;

  assign start = i_valid & ~valid_q & (state_q == IDLE);

  // Double-dabble step: per-nibble add-3 (no inter-nibble carry), then shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sr_q[W_BIN+4*i +: 4] >= 4'd5) begin
        sr_adj[W_BIN+4*i +: 4] = sr_q[W_BIN+4*i +: 4] + 4'd3;
      end
    end
    sr_shift = sr_adj << 1;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, i_bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = sr_shift[SR_W-1:W_BIN];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= i_valid;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (bcd_q[4*i +: 4] == 4'd0);
      blank[i]   = BLANK_LZ & (i > 0) & upper_zero;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    seg7_encoder u_enc (
      .bcd_i   (bcd_q[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (o_seg[7*g +: 7])
    );
  end

  assign o_busy      = (state_q == SHIFT);
  assign o_done      = done_q;
  assign o_bcd       = bcd_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: directed boundary cases plus random values,
// checked against a decimal-arithmetic model of the display.
module tb_bcd_display_driver;
  import bcd_display_pkg::*;

  localparam int W_BIN = 8;
  localparam int N_DIG = 3;
  localparam int LAT   = 8;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [20:0] seg;
  state_e      state_dbg;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [W_BIN-1:0] exp_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  bcd_display_driver #(.W_BIN(W_BIN), .N_DIGITS(N_DIG), .BLANK_LZ(1'b1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_bin       (bin),
    .o_busy      (busy),
    .o_done      (done),
    .o_bcd       (bcd),
    .o_seg       (seg),
    .o_state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: plain decimal arithmetic
  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] model_seg(input int v);
    logic [6:0] h, t, u;
    u = seg_tab[v % 10];
    t = (v < 10)  ? 7'h7F : seg_tab[(v / 10) % 10];
    h = (v < 100) ? 7'h7F : seg_tab[v / 100];
    return {h, t, u};
  endfunction

  // scoreboard: every done pulse must match the oldest captured value
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W_BIN-1:0] v;
        v = exp_q.pop_front();
        check($sformatf("bcd_%0d", v), 32'(bcd), 32'(model_bcd(int'(v))));
        check($sformatf("seg_%0d", v), 32'(seg), 32'(model_seg(int'(v))));
      end
    end
  end

  // driver: one conversion with cycle-exact busy/done checks.
  // mode 1 = glitch i_valid and change i_bin mid-conversion, mode 2 = reset at k+4
  task automatic run_conv(input logic [7:0] v, input int mode);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    bin   = v;
    valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check("busy_at_capture", 32'(busy), 32'd1);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk);
      #1;
      if (mode == 2 && c == 4) begin
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_seg", 32'(seg), {11'd0, 7'h7F, 7'h7F, 7'b1000000});
        return;
      end
      if (mode == 1 && c == 3) valid = 1'b0;
      if (mode == 1 && c == 4) begin
        valid = 1'b1;
        bin   = 8'd9;
      end
      if (c < LAT) begin
        check("done_early", 32'(done), 32'd0);
        check("busy_mid", 32'(busy), 32'd1);
      end else begin
        check("done_at_lat", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int busy_cycles;
    logic [7:0] dir_vals [8];
    dir_vals = '{8'd225, 8'd100, 8'd5, 8'd255, 8'd0, 8'd9, 8'd10, 8'd99};

    rst_n = 1'b0;
    valid = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_seg", 32'(seg), {11'd0, 7'h7F, 7'h7F, 7'b1000000});
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    foreach (dir_vals[i]) run_conv(dir_vals[i], 0);

    for (int i = 0; i < 20; i++) begin
      run_conv(8'($urandom_range(0, 255)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // edge during busy is dropped; held-high level after done starts nothing
    d0 = done_cnt;
    run_conv(8'd137, 1);
    repeat (12) @(posedge clk);
    #1;
    check("glitch_one_done", 32'(done_cnt - d0), 32'd1);
    check("glitch_idle", 32'(busy), 32'd0);

    // level held high for 40 cycles
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    bin   = 8'($urandom_range(0, 255));
    valid = 1'b1;
    exp_q.push_back(bin);
    d0 = done_cnt;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
    end
    @(negedge clk);
    check("hold_done_count", 32'(done_cnt - d0), 32'd1);
    check("hold_busy_cycles", 32'(busy_cycles), 32'd8);

    // reset mid-conversion aborts
    d0 = done_cnt;
    run_conv(8'd200, 2);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);

    run_conv(8'd42, 0);
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
